// File: rtl/oreg_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oreg_fifo: rounds/shifts a signed accumulator to DATABITS and buffers it     |
// | in a DEPTH-entry FIFO with valid/ready, occupancy and sticky overflow.       |
// | Optional: define OREG_FIFO_SAT_EN for saturation and the sticky sat_out.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module oreg_fifo #(
  parameter int DATABITS = 16,
  parameter int ACCBITS  = 32,
  parameter int SHIFT    = 15,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_in,
  input  logic                         ld_in,
  input  logic [ACCBITS-1:0]           acc_in,
  input  logic                         ready_in,
  output logic [DATABITS-1:0]          data_out,
  output logic                         data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         overflow_out
`ifdef OREG_FIFO_SAT_EN
  ,
  output logic                         sat_out
`endif
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0]    C_DEPTH = CNTW'(DEPTH);
  localparam logic [ACCBITS:0]   C_HALF  = {{ACCBITS{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [DATABITS-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]     r_wr_ptr;
  logic [PTRW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]     r_count;
  logic                r_overflow;

  logic signed [ACCBITS:0] w_rnd;
  logic signed [ACCBITS:0] w_shift;
  logic [DATABITS-1:0]     w_conv;
  logic                    w_valid;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  // One guard bit keeps the rounding add from overflowing at the positive limit.
  assign w_rnd   = $signed({acc_in[ACCBITS-1], acc_in}) + $signed(C_HALF);
  assign w_shift = w_rnd >>> SHIFT;

`ifdef OREG_FIFO_SAT_EN
  localparam logic [DATABITS-1:0] C_MAX = {1'b0, {(DATABITS-1){1'b1}}};
  localparam logic [DATABITS-1:0] C_MIN = {1'b1, {(DATABITS-1){1'b0}}};

  logic [ACCBITS-DATABITS+1:0] w_hi;
  logic                        w_sat_pos;
  logic                        w_sat_neg;
  logic                        r_sat;

  // The value fits only when every bit from the output sign upward matches.
  assign w_hi      = w_shift[ACCBITS:DATABITS-1];
  assign w_sat_pos = ~w_shift[ACCBITS] & (|w_hi);
  assign w_sat_neg = w_shift[ACCBITS] & ~(&w_hi);
  assign w_conv    = w_sat_pos ? C_MAX : (w_sat_neg ? C_MIN : w_shift[DATABITS-1:0]);
  assign sat_out   = r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (clr_in) begin
      r_sat <= 1'b0;
    end else if (w_push && (w_sat_pos || w_sat_neg)) begin
      r_sat <= 1'b1;
    end
  end
`else
  logic w_unused_hi;

  assign w_conv      = w_shift[DATABITS-1:0];
  assign w_unused_hi = ^w_shift[ACCBITS:DATABITS];
`endif

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = ready_in & w_valid & ~clr_in;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = ld_in & ~clr_in & (~w_full | w_pop);
  assign w_drop  = ld_in & ~clr_in & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_conv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTRW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTRW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNTW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNTW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign data_out       = w_valid ? r_mem[r_rd_ptr] : '0;
  assign data_valid_out = w_valid;
  assign count_out      = r_count;
  assign overflow_out   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_oreg_fifo.sv
`default_nettype none
// Self-checking bench for oreg_fifo: scoreboard queue plus literal checkpoints.
module tb_oreg_fifo;

  localparam int DATABITS = 16;
  localparam int ACCBITS  = 32;
  localparam int SHIFT    = 15;
  localparam int DEPTH    = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   clr_in;
  logic                   ld_in;
  logic [ACCBITS-1:0]     acc_in;
  logic                   ready_in;
  logic [DATABITS-1:0]    data_out;
  logic                   data_valid_out;
  logic [$clog2(DEPTH+1)-1:0] count_out;
  logic                   overflow_out;
`ifdef OREG_FIFO_SAT_EN
  logic                   sat_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATABITS-1:0] q[$];
  bit m_ovf = 0;
  bit m_sat = 0;

  oreg_fifo #(
    .DATABITS(DATABITS), .ACCBITS(ACCBITS), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr_in(clr_in),
    .ld_in(ld_in),
    .acc_in(acc_in),
    .ready_in(ready_in),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .count_out(count_out),
    .overflow_out(overflow_out)
`ifdef OREG_FIFO_SAT_EN
    ,
    .sat_out(sat_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint shifted(input logic [ACCBITS-1:0] a);
    longint v;
    v = longint'($signed(a));
    v = v + (longint'(1) <<< (SHIFT - 1));
    return v >>> SHIFT;
  endfunction

  function automatic bit sat_hit(input logic [ACCBITS-1:0] a);
    longint v;
    v = shifted(a);
    return (v > ((longint'(1) << (DATABITS - 1)) - 1)) || (v < -(longint'(1) << (DATABITS - 1)));
  endfunction

  function automatic logic [DATABITS-1:0] conv(input logic [ACCBITS-1:0] a);
    longint v;
    v = shifted(a);
`ifdef OREG_FIFO_SAT_EN
    if (v > ((longint'(1) << (DATABITS - 1)) - 1)) return {1'b0, {(DATABITS-1){1'b1}}};
    if (v < -(longint'(1) << (DATABITS - 1)))      return {1'b1, {(DATABITS-1){1'b0}}};
`endif
    return v[DATABITS-1:0];
  endfunction

  // One clock cycle: model the handshake, compare any pop, then check state after the edge.
  task automatic cyc(input bit ld, input logic [ACCBITS-1:0] acc, input bit rdy, input bit clr);
    int  n;
    bit  pop;
    bit  push;
    logic [DATABITS-1:0] exp_head;
    ld_in    = ld;
    acc_in   = acc;
    ready_in = rdy;
    clr_in   = clr;
    n = q.size();
    if (clr) begin
      q.delete();
      m_ovf = 0;
      m_sat = 0;
    end else begin
      pop  = rdy && (n > 0);
      push = ld && ((n < DEPTH) || pop);
      if (pop) check("pop_data", data_out, q.pop_front());
      if (push) begin
        q.push_back(conv(acc));
        if (sat_hit(acc)) m_sat = 1;
      end
      if (ld && !push) m_ovf = 1;
    end
    @(posedge clk);
    #1;
    ld_in    = 1'b0;
    ready_in = 1'b0;
    clr_in   = 1'b0;
    exp_head = (q.size() != 0) ? q[0] : '0;
    check("count", count_out, q.size());
    check("valid", data_valid_out, q.size() != 0);
    check("overflow", overflow_out, m_ovf);
    check("head", data_out, exp_head);
`ifdef OREG_FIFO_SAT_EN
    check("sat", sat_out, m_sat);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    clr_in   = 1'b0;
    ld_in    = 1'b0;
    acc_in   = '0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid_out, 0);
    check("rst_count", count_out, 0);
    check("rst_ovf", overflow_out, 0);
    rst_n = 1'b1;

    // Single push, held
    cyc(1, 32'h0000_4000, 0, 0);
    check("tp_single_data", data_out, 16'h0001);
    check("tp_single_count", count_out, 1);
    cyc(0, 0, 1, 0);

    // Rounding boundaries
    cyc(1, 32'h0000_3FFF, 0, 0);
    check("tp_rnd_3fff", data_out, 16'h0000);
    cyc(0, 0, 1, 0);
    cyc(1, 32'hFFFF_C000, 0, 0);
    check("tp_rnd_ffffc000", data_out, 16'h0000);
    cyc(0, 0, 1, 0);
    cyc(1, 32'hFFFF_8000, 0, 0);
    check("tp_rnd_ffff8000", data_out, 16'hFFFF);
    cyc(0, 0, 1, 0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) cyc(1, 32'(i) << 15, 0, 0);
    check("tp_fill_count", count_out, 4);
    check("tp_fill_ovf", overflow_out, 1);
    for (int i = 1; i <= 4; i++) begin
      check("tp_fill_pop", data_out, i);
      cyc(0, 0, 1, 0);
    end
    check("tp_fill_empty", data_valid_out, 0);
    cyc(0, 0, 0, 1);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) cyc(1, 32'(i) << 15, 0, 0);
    cyc(1, 32'h0005_0000, 1, 0);
    check("tp_fullpp_count", count_out, 4);
    check("tp_fullpp_ovf", overflow_out, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    check("tp_fullpp_last", data_out, 16'h000A);
    cyc(0, 0, 1, 0);

    // Flush priority
    for (int i = 1; i <= 3; i++) cyc(1, 32'(i) << 15, 0, 0);
    cyc(1, 32'h0000_8000, 1, 1);
    check("tp_clr_count", count_out, 0);
    check("tp_clr_valid", data_valid_out, 0);
    check("tp_clr_ovf", overflow_out, 0);
    check("tp_clr_data", data_out, 0);

    // Saturation / wrap
    cyc(1, 32'h4000_0000, 0, 0);
    cyc(1, 32'hBFFF_8000, 0, 0);
`ifdef OREG_FIFO_SAT_EN
    check("tp_sat_hi", data_out, 16'h7FFF);
    cyc(0, 0, 1, 0);
    check("tp_sat_lo", data_out, 16'h8000);
    check("tp_sat_flag", sat_out, 1);
`else
    check("tp_wrap_hi", data_out, 16'h8000);
    cyc(0, 0, 1, 0);
    check("tp_wrap_lo", data_out, 16'h7FFF);
`endif
    cyc(0, 0, 0, 1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      logic [ACCBITS-1:0] a;
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = ACCBITS'($signed($urandom_range(0, 64)) - 32) <<< ($urandom_range(13, 16));
      cyc(bit'($urandom_range(0, 2) != 0), a, bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset mid-operation, away from any clock edge
    for (int i = 1; i <= 5; i++) cyc(1, 32'(i) << 15, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count_out, 0);
    check("arst_valid", data_valid_out, 0);
    check("arst_ovf", overflow_out, 0);
    check("arst_data", data_out, 0);
    q.delete();
    m_ovf = 0;
    m_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h0001_8000, 0, 0);
    check("arst_after_push", data_out, 16'h0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
